briski_core_top: RTL and testbench

- Compute tile of a BRISKI row: a barrel-threaded core top with NUM_THREADS hardware threads (harts) sharing one pipeline.
- Each hart serves one issue slot in strict round-robin.
- This revision executes the built-in row-store program: acquire the row lock through the row-sync arbiter, have every hart store its hart ID into a strided URAM region, then release the lock and halt.
- Sits between the row arbiter/barrier logic and the row's shared URAM.

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/briski_pipe_delay.sv | 38 +++
 rtl/briski_core_top.sv | 125 ++++++++++++
 tb/tb_briski_core_top.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the BRISKI compute tile.
// Imported by the core top and its write delay line.
package riscv_pkg;

    typedef logic bool;

    localparam bool FALSE = 1'b0;

    localparam int NUM_PIPE_STAGES_DEF = 16;
    localparam int NUM_THREADS_DEF     = 16;

    localparam bool ENABLE_BRAM_REGFILE_DEF           = FALSE;
    localparam bool ENABLE_ALU_DSP_DEF                = FALSE;
    localparam bool ENABLE_UNIFIED_BARREL_SHIFTER_DEF = FALSE;

    localparam int URAM_ADDR_W = 12;
    localparam int URAM_DATA_W = 32;

    localparam int NUM_PASSES = 8;
    localparam int PASS_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } core_state_t;

    typedef struct packed {
        logic                   valid;
        logic [URAM_ADDR_W-1:0] addr;
        logic [URAM_DATA_W-1:0] data;
    } uram_wr_t;

endpackage

// File: rtl/briski_pipe_delay.sv
// Fixed-depth register delay line for URAM store beats.
// busy reports any beat still upstream of the output stage.
module briski_pipe_delay
    import riscv_pkg::*;
#(
    parameter int NUM_PIPE_STAGES = NUM_PIPE_STAGES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  uram_wr_t in_wr,
    output uram_wr_t out_wr,
    output logic     busy
);

    uram_wr_t stage_q [NUM_PIPE_STAGES];

    // Shift every beat one stage per cycle; reset empties the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PIPE_STAGES; i++)
                stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_wr;
            for (int i = 1; i < NUM_PIPE_STAGES; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_wr = stage_q[NUM_PIPE_STAGES-1];

    // A beat is still in flight if any non-output stage holds one.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_PIPE_STAGES - 1; i++)
            busy = busy | stage_q[i].valid;
    end

endmodule

// File: rtl/briski_core_top.sv
// Barrel-threaded BRISKI tile running the built-in row-store program:
// lock the row, each hart stores its ID into a strided URAM region, unlock.
module briski_core_top
    import riscv_pkg::*;
#(
    parameter     BRAM_DATA_INSTR_FILE          = "none",
    parameter int NUM_PIPE_STAGES               = NUM_PIPE_STAGES_DEF,
    parameter int NUM_THREADS                   = NUM_THREADS_DEF,
    parameter bool ENABLE_BRAM_REGFILE          = ENABLE_BRAM_REGFILE_DEF,
    parameter bool ENABLE_ALU_DSP               = ENABLE_ALU_DSP_DEF,
    parameter bool ENABLE_UNIFIED_BARREL_SHIFTER = ENABLE_UNIFIED_BARREL_SHIFTER_DEF,
    parameter int IDcluster                     = 0,
    parameter int IDrow                         = 0,
    parameter int IDminirow                     = 0,
    parameter int IDposx                        = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   o_URAM_en,
    output logic [URAM_ADDR_W-1:0] o_URAM_addr,
    output logic [URAM_DATA_W-1:0] o_URAM_wr_data,
    output logic                   o_URAM_wr_en,
    input  logic                   i_uram_emptied,
    output logic                   o_core_req,
    output logic                   o_core_locked,
    input  logic                   i_core_grant
);

    localparam int SLOT_W = $clog2(NUM_THREADS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_THREADS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
    localparam bit IMG_GIVEN = (BRAM_DATA_INSTR_FILE != "none");

    core_state_t       state_q;
    core_state_t       state_d;
    logic [SLOT_W-1:0] slot_q;
    logic [PASS_W-1:0] pass_q;
    logic              issue;
    logic              last_issue;
    logic              busy;
    uram_wr_t          issue_wr;
    uram_wr_t          port_wr;

    assign last_issue = (slot_q == LAST_SLOT) && (pass_q == LAST_PASS);

    // State register plus hart slot / pass counters advanced per issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                slot_q <= slot_q + 1'b1;
                if (slot_q == LAST_SLOT)
                    pass_q <= pass_q + 1'b1;
            end
        end
    end

    // Next state and lock handshake; grant is only sampled in REQ.
    always_comb begin
        state_d       = state_q;
        issue         = 1'b0;
        o_core_req    = 1'b0;
        o_core_locked = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                o_core_req = 1'b1;
                if (i_core_grant)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                o_core_req    = 1'b1;
                o_core_locked = 1'b1;
                issue         = 1'b1;
                if (last_issue)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_core_req    = 1'b1;
                o_core_locked = 1'b1;
                if (!busy)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Store of hart slot_q in pass pass_q: addr = pass + 8*hart.
    always_comb begin
        issue_wr = '0;
        if (issue) begin
            issue_wr.valid = 1'b1;
            issue_wr.addr  = URAM_ADDR_W'({slot_q, pass_q});
            issue_wr.data  = URAM_DATA_W'(slot_q);
        end
    end

    briski_pipe_delay #(
        .NUM_PIPE_STAGES(NUM_PIPE_STAGES)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .in_wr (issue_wr),
        .out_wr(port_wr),
        .busy  (busy)
    );

    assign o_URAM_en      = port_wr.valid;
    assign o_URAM_wr_en   = port_wr.valid;
    assign o_URAM_addr    = port_wr.addr;
    assign o_URAM_wr_data = port_wr.data;

    logic unused_ok;
    assign unused_ok = &{1'b0, i_uram_emptied, IMG_GIVEN,
                         ENABLE_BRAM_REGFILE, ENABLE_ALU_DSP,
                         ENABLE_UNIFIED_BARREL_SHIFTER,
                         (IDcluster != 0), (IDrow != 0),
                         (IDminirow != 0), (IDposx != 0)};

endmodule

// File: tb/tb_briski_core_top.sv
// Bench for briski_core_top: two instances (deep and single-stage pipe)
// share stimulus; each write stream is compared to the row-store model.
module tb_briski_core_top;

    localparam int NT  = 16;
    localparam int PS0 = 16;
    localparam int PS1 = 1;
    localparam int NW  = 8 * NT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        grant = 1'b0;
    logic        emptied = 1'b0;
    logic [1:0]  en;
    logic [1:0]  wr_en;
    logic [1:0]  req;
    logic [1:0]  locked;
    logic [11:0] addr [2];
    logic [31:0] data [2];

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    briski_core_top #(
        .NUM_PIPE_STAGES(PS0),
        .NUM_THREADS    (NT)
    ) u_dut0 (
        .clk           (clk),
        .reset         (reset),
        .o_URAM_en     (en[0]),
        .o_URAM_addr   (addr[0]),
        .o_URAM_wr_data(data[0]),
        .o_URAM_wr_en  (wr_en[0]),
        .i_uram_emptied(emptied),
        .o_core_req    (req[0]),
        .o_core_locked (locked[0]),
        .i_core_grant  (grant)
    );

    briski_core_top #(
        .NUM_PIPE_STAGES(PS1),
        .NUM_THREADS    (NT)
    ) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .o_URAM_en     (en[1]),
        .o_URAM_addr   (addr[1]),
        .o_URAM_wr_data(data[1]),
        .o_URAM_wr_en  (wr_en[1]),
        .i_uram_emptied(emptied),
        .o_core_req    (req[1]),
        .o_core_locked (locked[1]),
        .i_core_grant  (grant)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_emptied();
        int p;
        p = $urandom_range(0, 2);
        emptied = (p == 0) ? 1'b0 : (p == 1) ? 1'b1 : 1'bx;
    endtask

    task automatic all_zero(input string tag);
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d_%s", d, tag),
                {en[d], wr_en[d], req[d], locked[d], addr[d], data[d]},
                '0);
    endtask

    // gdelay: cycles from req to grant; gdrop: drop grant this many
    // cycles after lock (0 = never); abort_k: reset after k writes.
    task automatic run_seq(input int gdelay,
                           input int gdrop,
                           input int abort_k);
        int  cyc, req_cyc, grant_cyc, k, last_fall;
        bit  dropped, fin, aborted;
        int  wcnt [2];
        int  first_wr [2];
        int  lock_rise [2];
        int  lock_fall [2];
        int  last_wr [2];
        int  ps [2];
        bit  prev_lk [2];

        ps[0] = PS0;
        ps[1] = PS1;
        reset = 1'b0;
        grant = 1'b0;
        repeat (20) begin
            @(negedge clk);
            drive_emptied();
        end
        all_zero("in_reset");

        for (int d = 0; d < 2; d++) begin
            wcnt[d] = 0;
            first_wr[d] = -1;
            lock_rise[d] = -1;
            lock_fall[d] = -1;
            last_wr[d] = -1;
            prev_lk[d] = 1'b0;
        end
        cyc = 0;
        req_cyc = -1;
        grant_cyc = -1;
        dropped = 1'b0;
        fin = 1'b0;
        aborted = 1'b0;
        reset = 1'b1;

        for (int n = 0; n < 800 && !fin; n++) begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (locked[d] && !prev_lk[d]) begin
                    lock_rise[d] = cyc;
                    chk($sformatf("d%0d_lock_rise", d), cyc, grant_cyc + 1);
                end
                if (!locked[d] && prev_lk[d]) begin
                    lock_fall[d] = cyc;
                    chk($sformatf("d%0d_lock_fall", d), cyc, last_wr[d] + 1);
                    chk($sformatf("d%0d_fall_total", d), wcnt[d], NW);
                end
                prev_lk[d] = locked[d];
                if (lock_rise[d] >= 0 && lock_fall[d] < 0)
                    chk($sformatf("d%0d_req_held", d), req[d], 1);
                if (lock_fall[d] >= 0)
                    chk($sformatf("d%0d_done_quiet", d),
                        {req[d], locked[d], en[d]}, 0);
                if (en[d]) begin
                    k = wcnt[d];
                    if (k == 0) begin
                        first_wr[d] = cyc;
                        chk($sformatf("d%0d_latency", d),
                            cyc, lock_rise[d] + ps[d]);
                    end
                    chk($sformatf("d%0d_gapless", d), cyc, first_wr[d] + k);
                    chk($sformatf("d%0d_wr_locked", d), locked[d], 1);
                    chk($sformatf("d%0d_wr_en", d), wr_en[d], 1);
                    chk($sformatf("d%0d_addr_k%0d", d, k),
                        addr[d], (k / NT) + 8 * (k % NT));
                    chk($sformatf("d%0d_data_k%0d", d, k),
                        data[d], k % NT);
                    chk($sformatf("d%0d_wr_count", d), k < NW, 1);
                    last_wr[d] = cyc;
                    wcnt[d]++;
                end else begin
                    chk($sformatf("d%0d_idle_bus", d),
                        {wr_en[d], addr[d], data[d]}, 0);
                end
            end

            if (abort_k >= 0 && wcnt[0] == abort_k) begin
                reset = 1'b0;
                #1;
                all_zero("abort_clear");
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                if (req_cyc < 0 && req[0])
                    req_cyc = cyc;
                if (!dropped && grant_cyc < 0 && req_cyc >= 0 &&
                    cyc >= req_cyc + gdelay) begin
                    grant = 1'b1;
                    grant_cyc = cyc;
                end
                if (gdrop > 0 && grant && lock_rise[0] >= 0 &&
                    cyc >= lock_rise[0] + gdrop) begin
                    grant = 1'b0;
                    dropped = 1'b1;
                end
                drive_emptied();
                if (lock_fall[0] >= 0 && lock_fall[1] >= 0) begin
                    last_fall = (lock_fall[0] > lock_fall[1]) ?
                                lock_fall[0] : lock_fall[1];
                    if (cyc >= last_fall + 100)
                        fin = 1'b1;
                end
            end
        end

        if (!aborted) begin
            chk("seq_finished", fin, 1);
            for (int d = 0; d < 2; d++)
                chk($sformatf("d%0d_wr_total", d), wcnt[d], NW);
        end
    endtask

    initial begin
        run_seq(1, 0, -1);
        run_seq(20, 10, -1);
        run_seq($urandom_range(1, 4), 0, 50);
        run_seq($urandom_range(1, 6), $urandom_range(1, 120), -1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
